// File: rtl/cpu_control_unit_if.sv
// Strobe/handshake bundle between cpu_control_unit (master) and DataPath (slave).
// mem_rdy exists only when CTRL_MEM_WAIT_EN is defined.
interface cpu_control_unit_if #(
  parameter int OPW = 5,
  parameter int IRW = 32
);
  logic [IRW-1:0] IR;
  logic           CON;
`ifdef CTRL_MEM_WAIT_EN
  logic           mem_rdy;
`endif
  logic PCout, Zlowout, Zhighout, MDRout;
  logic MARin, Zin, PCin, MDRin, IRin, Yin, IncPC;
  logic Read, Write;
  logic Gra, Grb, Grc, Rin, Rout, BAout, Cout;
  logic LOin, HIin, CONin;
  logic [OPW-1:0] Operator;
  logic           run;
  logic [4:0]     state_dbg;

  modport master (
    input  IR, CON,
`ifdef CTRL_MEM_WAIT_EN
    input  mem_rdy,
`endif
    output PCout, Zlowout, Zhighout, MDRout,
    output MARin, Zin, PCin, MDRin, IRin, Yin, IncPC,
    output Read, Write,
    output Gra, Grb, Grc, Rin, Rout, BAout, Cout,
    output LOin, HIin, CONin,
    output Operator, run, state_dbg
  );

  modport slave (
    output IR, CON,
`ifdef CTRL_MEM_WAIT_EN
    output mem_rdy,
`endif
    input  PCout, Zlowout, Zhighout, MDRout,
    input  MARin, Zin, PCin, MDRin, IRin, Yin, IncPC,
    input  Read, Write,
    input  Gra, Grb, Grc, Rin, Rout, BAout, Cout,
    input  LOin, HIin, CONin,
    input  Operator, run, state_dbg
  );
endinterface

// File: rtl/cpu_control_unit.sv
// Hardwired Moore fetch/execute sequencer driving DataPath strobes.
// Optional CTRL_MEM_WAIT_EN: Read/Write states stall until mem_rdy.
//
//   state  | meaning
//   RST    | in clear, all strobes low, run low
//   T0..T2 | common fetch
//   T3..T7 | execute step, decoded from IR[31:27]
//   HALT   | halted until clear
module cpu_control_unit #(
  parameter int OPW = 5,
  parameter int IRW = 32
) (
  input logic                clk,
  input logic                clear,
  cpu_control_unit_if.master bus
);

  typedef enum logic [4:0] {
    S_RST  = 5'd0,
    S_T0   = 5'd1,
    S_T1   = 5'd2,
    S_T2   = 5'd3,
    S_T3   = 5'd4,
    S_T4   = 5'd5,
    S_T5   = 5'd6,
    S_T6   = 5'd7,
    S_T7   = 5'd8,
    S_HALT = 5'd9
  } state_e;

  typedef struct packed {
    logic           pc_out, zlo_out, zhi_out, mdr_out;
    logic           mar_in, z_in, pc_in, mdr_in, ir_in, y_in, inc_pc;
    logic           read, write;
    logic           gra, grb, grc, r_in, r_out, ba_out, c_out;
    logic           lo_in, hi_in, con_in;
    logic           br_pc;
    logic [OPW-1:0] alu_op;
    logic           run;
  } ctrl_t;

  localparam logic [OPW-1:0] OP_LD   = OPW'(0);
  localparam logic [OPW-1:0] OP_LDI  = OPW'(1);
  localparam logic [OPW-1:0] OP_ST   = OPW'(2);
  localparam logic [OPW-1:0] OP_ADD  = OPW'(3);
  localparam logic [OPW-1:0] OP_AND  = OPW'(10);
  localparam logic [OPW-1:0] OP_OR   = OPW'(11);
  localparam logic [OPW-1:0] OP_ADDI = OPW'(12);
  localparam logic [OPW-1:0] OP_ANDI = OPW'(13);
  localparam logic [OPW-1:0] OP_ORI  = OPW'(14);
  localparam logic [OPW-1:0] OP_MUL  = OPW'(15);
  localparam logic [OPW-1:0] OP_DIV  = OPW'(16);
  localparam logic [OPW-1:0] OP_NEG  = OPW'(17);
  localparam logic [OPW-1:0] OP_NOT  = OPW'(18);
  localparam logic [OPW-1:0] OP_BR   = OPW'(19);
  localparam logic [OPW-1:0] OP_JR   = OPW'(20);
  localparam logic [OPW-1:0] OP_HALT = OPW'(27);

  state_e         state_q, state_d;
  ctrl_t          ctrl_q, ctrl_d;
  logic [OPW-1:0] opcode;
  logic           unused_ir;

  assign opcode    = bus.IR[IRW-1 -: OPW];
  assign unused_ir = ^bus.IR[IRW-OPW-1:0];

  // Final execute state per instruction class; anything unlisted ends after fetch.
  function automatic state_e last_state(input logic [OPW-1:0] op);
    state_e s;
    if (op == OP_JR)                                           s = S_T3;
    else if (op == OP_NEG || op == OP_NOT)                     s = S_T4;
    else if ((op >= OP_ADD && op <= OP_ORI) || op == OP_LDI)   s = S_T5;
    else if (op == OP_MUL || op == OP_DIV || op == OP_BR)      s = S_T6;
    else if (op == OP_LD || op == OP_ST)                       s = S_T7;
    else                                                       s = S_T2;
    return s;
  endfunction

  function automatic ctrl_t decode(input state_e s, input logic [OPW-1:0] op);
    ctrl_t c;
    logic  r_alu, i_alu, un_alu, md, mem, is_br, is_jr;
    c      = '0;
    r_alu  = (op >= OP_ADD) && (op <= OP_OR);
    i_alu  = (op >= OP_ADDI) && (op <= OP_ORI);
    un_alu = (op == OP_NEG) || (op == OP_NOT);
    md     = (op == OP_MUL) || (op == OP_DIV);
    mem    = (op == OP_LD) || (op == OP_LDI) || (op == OP_ST);
    is_br  = (op == OP_BR);
    is_jr  = (op == OP_JR);
    c.run  = (s != S_RST) && (s != S_HALT);
    case (s)
      S_T0: begin c.pc_out = 1'b1; c.mar_in = 1'b1; c.inc_pc = 1'b1; c.z_in = 1'b1; end
      S_T1: begin c.zlo_out = 1'b1; c.pc_in = 1'b1; c.read = 1'b1; c.mdr_in = 1'b1; end
      S_T2: begin c.mdr_out = 1'b1; c.ir_in = 1'b1; end
      S_T3: begin
        if (r_alu || i_alu) begin c.grb = 1'b1; c.r_out = 1'b1; c.y_in = 1'b1; end
        else if (un_alu)    begin c.grb = 1'b1; c.r_out = 1'b1; c.z_in = 1'b1; c.alu_op = op; end
        else if (md)        begin c.gra = 1'b1; c.r_out = 1'b1; c.y_in = 1'b1; end
        else if (mem)       begin c.grb = 1'b1; c.ba_out = 1'b1; c.y_in = 1'b1; end
        else if (is_br)     begin c.gra = 1'b1; c.r_out = 1'b1; c.con_in = 1'b1; end
        else if (is_jr)     begin c.gra = 1'b1; c.r_out = 1'b1; c.pc_in = 1'b1; end
      end
      S_T4: begin
        if (r_alu)       begin c.grc = 1'b1; c.r_out = 1'b1; c.z_in = 1'b1; c.alu_op = op; end
        else if (i_alu) begin
          c.c_out  = 1'b1;
          c.z_in   = 1'b1;
          c.alu_op = (op == OP_ADDI) ? OP_ADD : (op == OP_ANDI) ? OP_AND : OP_OR;
        end
        else if (un_alu) begin c.zlo_out = 1'b1; c.gra = 1'b1; c.r_in = 1'b1; end
        else if (md)     begin c.grb = 1'b1; c.r_out = 1'b1; c.z_in = 1'b1; c.alu_op = op; end
        else if (mem)    begin c.c_out = 1'b1; c.z_in = 1'b1; c.alu_op = OP_ADD; end
        else if (is_br)  begin c.pc_out = 1'b1; c.y_in = 1'b1; end
      end
      S_T5: begin
        if (r_alu || i_alu || op == OP_LDI) begin c.zlo_out = 1'b1; c.gra = 1'b1; c.r_in = 1'b1; end
        else if (md)    begin c.zlo_out = 1'b1; c.lo_in = 1'b1; end
        else if (mem)   begin c.zlo_out = 1'b1; c.mar_in = 1'b1; end
        else if (is_br) begin c.c_out = 1'b1; c.z_in = 1'b1; c.alu_op = OP_ADD; end
      end
      S_T6: begin
        if (md)                begin c.zhi_out = 1'b1; c.hi_in = 1'b1; end
        else if (op == OP_LD)  begin c.read = 1'b1; c.mdr_in = 1'b1; end
        else if (op == OP_ST)  begin c.gra = 1'b1; c.r_out = 1'b1; c.mdr_in = 1'b1; end
        else if (is_br)        begin c.zlo_out = 1'b1; c.br_pc = 1'b1; end
      end
      S_T7: begin
        if (op == OP_LD)      begin c.mdr_out = 1'b1; c.gra = 1'b1; c.r_in = 1'b1; end
        else if (op == OP_ST) c.write = 1'b1;
      end
      default: ;
    endcase
    return c;
  endfunction

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RST:  state_d = S_T0;
      S_HALT: state_d = S_HALT;
      S_T2: begin
        if (opcode == OP_HALT)               state_d = S_HALT;
        else if (last_state(opcode) == S_T2) state_d = S_T0;
        else                                 state_d = S_T3;
      end
      default: begin
        if (state_q == last_state(opcode)) state_d = S_T0;
        else                               state_d = state_e'(state_q + 5'd1);
      end
    endcase
`ifdef CTRL_MEM_WAIT_EN
    if (!bus.mem_rdy && ((state_q == S_T1) ||
                         (state_q == S_T6 && opcode == OP_LD) ||
                         (state_q == S_T7 && opcode == OP_ST)))
      state_d = state_q;
`endif
    ctrl_d = decode(state_d, opcode);
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state_q <= S_RST;
      ctrl_q  <= '0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
    end
  end

  // The branch target load waits for CON as seen during T6 itself.
  assign bus.PCin      = ctrl_q.pc_in | (ctrl_q.br_pc & bus.CON);
  assign bus.PCout     = ctrl_q.pc_out;
  assign bus.Zlowout   = ctrl_q.zlo_out;
  assign bus.Zhighout  = ctrl_q.zhi_out;
  assign bus.MDRout    = ctrl_q.mdr_out;
  assign bus.MARin     = ctrl_q.mar_in;
  assign bus.Zin       = ctrl_q.z_in;
  assign bus.MDRin     = ctrl_q.mdr_in;
  assign bus.IRin      = ctrl_q.ir_in;
  assign bus.Yin       = ctrl_q.y_in;
  assign bus.IncPC     = ctrl_q.inc_pc;
  assign bus.Read      = ctrl_q.read;
  assign bus.Write     = ctrl_q.write;
  assign bus.Gra       = ctrl_q.gra;
  assign bus.Grb       = ctrl_q.grb;
  assign bus.Grc       = ctrl_q.grc;
  assign bus.Rin       = ctrl_q.r_in;
  assign bus.Rout      = ctrl_q.r_out;
  assign bus.BAout     = ctrl_q.ba_out;
  assign bus.Cout      = ctrl_q.c_out;
  assign bus.LOin      = ctrl_q.lo_in;
  assign bus.HIin      = ctrl_q.hi_in;
  assign bus.CONin     = ctrl_q.con_in;
  assign bus.Operator  = ctrl_q.alu_op;
  assign bus.run       = ctrl_q.run;
  assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_cpu_control_unit.sv
// Self-checking bench for cpu_control_unit: per-instruction strobe schedules
// built from the instruction-level rules, directed and random opcodes.
module tb_cpu_control_unit;
  localparam int OPW = 5;
  localparam int IRW = 32;

  logic clk = 1'b0;
  logic clear;
  int   errors = 0;
  int   checks = 0;

  cpu_control_unit_if #(.OPW(OPW), .IRW(IRW)) bus_if ();
  cpu_control_unit #(.OPW(OPW), .IRW(IRW)) dut (.clk(clk), .clear(clear), .bus(bus_if));

  always #5 clk = ~clk;

  localparam logic [22:0] M_PCOUT  = 23'(1) << 0;
  localparam logic [22:0] M_ZLO    = 23'(1) << 1;
  localparam logic [22:0] M_ZHI    = 23'(1) << 2;
  localparam logic [22:0] M_MDROUT = 23'(1) << 3;
  localparam logic [22:0] M_MARIN  = 23'(1) << 4;
  localparam logic [22:0] M_ZIN    = 23'(1) << 5;
  localparam logic [22:0] M_PCIN   = 23'(1) << 6;
  localparam logic [22:0] M_MDRIN  = 23'(1) << 7;
  localparam logic [22:0] M_IRIN   = 23'(1) << 8;
  localparam logic [22:0] M_YIN    = 23'(1) << 9;
  localparam logic [22:0] M_INCPC  = 23'(1) << 10;
  localparam logic [22:0] M_READ   = 23'(1) << 11;
  localparam logic [22:0] M_WRITE  = 23'(1) << 12;
  localparam logic [22:0] M_GRA    = 23'(1) << 13;
  localparam logic [22:0] M_GRB    = 23'(1) << 14;
  localparam logic [22:0] M_GRC    = 23'(1) << 15;
  localparam logic [22:0] M_RIN    = 23'(1) << 16;
  localparam logic [22:0] M_ROUT   = 23'(1) << 17;
  localparam logic [22:0] M_BAOUT  = 23'(1) << 18;
  localparam logic [22:0] M_COUT   = 23'(1) << 19;
  localparam logic [22:0] M_LOIN   = 23'(1) << 20;
  localparam logic [22:0] M_HIIN   = 23'(1) << 21;
  localparam logic [22:0] M_CONIN  = 23'(1) << 22;
  localparam logic [22:0] M_T0     = M_PCOUT | M_MARIN | M_INCPC | M_ZIN;

  typedef struct packed {
    logic [22:0] m;
    logic [4:0]  op;
    logic        run;
  } obs_t;

  obs_t exp_q[$];

  function automatic obs_t mk(input logic [22:0] m, input logic [4:0] op, input logic run);
    obs_t o;
    o.m = m; o.op = op; o.run = run;
    return o;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o.m = {bus_if.CONin, bus_if.HIin, bus_if.LOin, bus_if.Cout, bus_if.BAout, bus_if.Rout,
           bus_if.Rin, bus_if.Grc, bus_if.Grb, bus_if.Gra, bus_if.Write, bus_if.Read,
           bus_if.IncPC, bus_if.Yin, bus_if.IRin, bus_if.MDRin, bus_if.PCin, bus_if.Zin,
           bus_if.MARin, bus_if.MDRout, bus_if.Zhighout, bus_if.Zlowout, bus_if.PCout};
    o.op  = bus_if.Operator;
    o.run = bus_if.run;
    return o;
  endfunction

  task automatic push(input logic [22:0] m, input logic [4:0] op);
    exp_q.push_back(mk(m, op, 1'b1));
  endtask

  // Cycle-by-cycle schedule for one instruction, fetch included.
  task automatic build_seq(input int op, input logic con);
    exp_q.delete();
    push(M_T0, 5'd0);
    push(M_ZLO | M_PCIN | M_READ | M_MDRIN, 5'd0);
    push(M_MDROUT | M_IRIN, 5'd0);
    if (op >= 3 && op <= 11) begin
      push(M_GRB | M_ROUT | M_YIN, 5'd0);
      push(M_GRC | M_ROUT | M_ZIN, 5'(op));
      push(M_ZLO | M_GRA | M_RIN, 5'd0);
    end else if (op >= 12 && op <= 14) begin
      push(M_GRB | M_ROUT | M_YIN, 5'd0);
      push(M_COUT | M_ZIN, (op == 12) ? 5'd3 : (op == 13) ? 5'd10 : 5'd11);
      push(M_ZLO | M_GRA | M_RIN, 5'd0);
    end else if (op == 17 || op == 18) begin
      push(M_GRB | M_ROUT | M_ZIN, 5'(op));
      push(M_ZLO | M_GRA | M_RIN, 5'd0);
    end else if (op == 15 || op == 16) begin
      push(M_GRA | M_ROUT | M_YIN, 5'd0);
      push(M_GRB | M_ROUT | M_ZIN, 5'(op));
      push(M_ZLO | M_LOIN, 5'd0);
      push(M_ZHI | M_HIIN, 5'd0);
    end else if (op <= 2) begin
      push(M_GRB | M_BAOUT | M_YIN, 5'd0);
      push(M_COUT | M_ZIN, 5'd3);
      if (op == 1) push(M_ZLO | M_GRA | M_RIN, 5'd0);
      else begin
        push(M_ZLO | M_MARIN, 5'd0);
        if (op == 0) begin
          push(M_READ | M_MDRIN, 5'd0);
          push(M_MDROUT | M_GRA | M_RIN, 5'd0);
        end else begin
          push(M_GRA | M_ROUT | M_MDRIN, 5'd0);
          push(M_WRITE, 5'd0);
        end
      end
    end else if (op == 19) begin
      push(M_GRA | M_ROUT | M_CONIN, 5'd0);
      push(M_PCOUT | M_YIN, 5'd0);
      push(M_COUT | M_ZIN, 5'd3);
      push(M_ZLO | (con ? M_PCIN : 23'd0), 5'd0);
    end else if (op == 20) begin
      push(M_GRA | M_ROUT | M_PCIN, 5'd0);
    end
  endtask

  function automatic int latency_of(input int op);
    if (op == 20) return 4;
    if (op == 17 || op == 18) return 5;
    if ((op >= 3 && op <= 14) || op == 1) return 6;
    if (op == 15 || op == 16 || op == 19) return 7;
    if (op == 0 || op == 2) return 8;
    return 3;
  endfunction

  task automatic check_bus_rules(input string name);
    obs_t o;
    o = sample();
    checks++;
    if ($countones({bus_if.PCout, bus_if.Zlowout, bus_if.Zhighout, bus_if.MDRout,
                    bus_if.Rout, bus_if.BAout, bus_if.Cout}) > 1 || (bus_if.Read && bus_if.Write)) begin
      errors++;
      $display("FAIL %s bus_rules: got strobes=%h, required at most one bus driver and not Read&Write",
               name, o.m);
    end
  endtask

  // Entered at a negedge in T0; leaves at the negedge of the following T0.
  task automatic run_instr(input logic [31:0] ir, input logic con, input string name);
    obs_t o;
    int   op;
    bus_if.IR  = ir;
    bus_if.CON = con;
    op = int'(ir[31:27]);
    build_seq(op, con);
    for (int i = 0; i < exp_q.size(); i++) begin
      o = sample();
      checks++;
      if (o !== exp_q[i]) begin
        errors++;
        $display("FAIL %s step %0d: got m=%h op=%h run=%b, required m=%h op=%h run=%b",
                 name, i, o.m, o.op, o.run, exp_q[i].m, exp_q[i].op, exp_q[i].run);
      end
      check_bus_rules(name);
      @(negedge clk);
    end
    o = sample();
    checks++;
    if (o !== mk(M_T0, 5'd0, 1'b1)) begin
      errors++;
      $display("FAIL %s next_T0: got m=%h op=%h run=%b, required m=%h op=0 run=1",
               name, o.m, o.op, o.run, M_T0);
    end
  endtask

  task automatic expect_idle(input string name);
    obs_t o;
    o = sample();
    checks++;
    if (o !== mk(23'd0, 5'd0, 1'b0)) begin
      errors++;
      $display("FAIL %s idle: got m=%h op=%h run=%b, required all zero",
               name, o.m, o.op, o.run);
    end
  endtask

  task automatic expect_t0(input string name);
    obs_t o;
    o = sample();
    checks++;
    if (o !== mk(M_T0, 5'd0, 1'b1)) begin
      errors++;
      $display("FAIL %s t0: got m=%h op=%h run=%b, required m=%h op=0 run=1",
               name, o.m, o.op, o.run, M_T0);
    end
  endtask

  task automatic test_reset();
    clear = 1'b1;
    @(negedge clk);
    expect_idle("reset_c1");
    @(negedge clk);
    expect_idle("reset_c2");
    clear = 1'b0;
    @(negedge clk);
    expect_t0("reset_exit");
  endtask

  task automatic test_directed();
    run_instr(32'h1A920000, 1'b0, "add");
    run_instr(32'h00900054, 1'b0, "ld");
    run_instr(32'h99800010, 1'b1, "br_taken");
    run_instr(32'h99800010, 1'b0, "br_not_taken");
    run_instr(32'h11000000, 1'b0, "st");
    run_instr(32'h69000007, 1'b1, "andi");
  endtask

  task automatic test_latency();
    int ops[12] = '{26, 20, 17, 3, 1, 15, 19, 0, 2, 12, 5, 31};
    int cnt;
    bit seen;
    for (int k = 0; k < 12; k++) begin
      bus_if.IR  = {5'(ops[k]), 27'h0};
      bus_if.CON = 1'b0;
      cnt  = 0;
      seen = 1'b0;
      while (!seen && cnt < 20) begin
        @(negedge clk);
        cnt++;
        if (sample() === mk(M_T0, 5'd0, 1'b1)) seen = 1'b1;
      end
      checks++;
      if (!seen || cnt != latency_of(ops[k])) begin
        errors++;
        $display("FAIL latency op=%0d: got %0d cycles (returned=%0b), required %0d",
                 ops[k], cnt, seen, latency_of(ops[k]));
        if (!seen) begin
          clear = 1'b1; @(negedge clk); clear = 1'b0; @(negedge clk);
        end
      end
    end
  endtask

  task automatic test_halt();
    obs_t o;
    bus_if.IR = 32'hD8000000;
    build_seq(27, 1'b0);
    for (int i = 0; i < 3; i++) begin
      o = sample();
      checks++;
      if (o !== exp_q[i]) begin
        errors++;
        $display("FAIL halt_fetch step %0d: got m=%h op=%h run=%b, required m=%h",
                 i, o.m, o.op, o.run, exp_q[i].m);
      end
      @(negedge clk);
    end
    for (int i = 0; i < 10; i++) begin
      expect_idle("halt_hold");
      @(negedge clk);
    end
    clear = 1'b1;
    @(negedge clk);
    expect_idle("halt_clear");
    clear = 1'b0;
    @(negedge clk);
    expect_t0("halt_restart");
  endtask

  task automatic test_clear_mid_mul();
    obs_t o;
    bus_if.IR = {5'd15, 27'h0123456};
    build_seq(15, 1'b0);
    for (int i = 0; i < 6; i++) begin
      o = sample();
      checks++;
      if (o !== exp_q[i]) begin
        errors++;
        $display("FAIL mul_abort step %0d: got m=%h op=%h run=%b, required m=%h op=%h",
                 i, o.m, o.op, o.run, exp_q[i].m, exp_q[i].op);
      end
      if (i == 5) clear = 1'b1;
      @(negedge clk);
    end
    expect_idle("mul_abort_rst");
    clear = 1'b0;
    @(negedge clk);
    expect_t0("mul_abort_t0");
  endtask

`ifdef CTRL_MEM_WAIT_EN
  task automatic test_mem_wait();
    obs_t o;
    bus_if.IR = 32'h1A920000;
    build_seq(3, 1'b0);
    bus_if.mem_rdy = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      o = sample();
      checks++;
      if (o !== exp_q[1]) begin
        errors++;
        $display("FAIL mem_wait hold %0d: got m=%h, required m=%h", i, o.m, exp_q[1].m);
      end
      if (i == 3) bus_if.mem_rdy = 1'b1;
      else if (i < 3) @(negedge clk);
    end
    for (int i = 2; i < exp_q.size(); i++) begin
      @(negedge clk);
      o = sample();
      checks++;
      if (o !== exp_q[i]) begin
        errors++;
        $display("FAIL mem_wait step %0d: got m=%h op=%h, required m=%h op=%h",
                 i, o.m, o.op, exp_q[i].m, exp_q[i].op);
      end
    end
    @(negedge clk);
    expect_t0("mem_wait_t0");
  endtask
`endif

  task automatic test_random();
    int          op;
    logic [31:0] ir;
    for (int n = 0; n < 40; n++) begin
      op = int'($urandom_range(0, 31));
      if (op == 27) op = 26;
      ir = {5'(op), 27'($urandom)};
      run_instr(ir, 1'($urandom_range(0, 1)), $sformatf("rand%0d_op%0d", n, op));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    bus_if.IR  = 32'h0;
    bus_if.CON = 1'b0;
`ifdef CTRL_MEM_WAIT_EN
    bus_if.mem_rdy = 1'b1;
`endif
    test_reset();
    test_directed();
    test_latency();
    test_halt();
    test_clear_mid_mul();
`ifdef CTRL_MEM_WAIT_EN
    test_mem_wait();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
